// File: rtl/debug_pkg.sv
// Shared definitions for the debug display controller: run-control state
// encoding and the seven-segment patterns (gfedcba, active-low).
package debug_pkg;

  typedef enum logic [1:0] {
    ST_HALT = 2'd0,
    ST_STEP = 2'd1,
    ST_RUN  = 2'd2
  } run_state_t;

  // All segments off.
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  // Hex glyphs, entry 15 first so SEG_TABLE[n] selects the glyph for nibble n.
  localparam logic [15:0][6:0] SEG_TABLE = {
    7'b0001110,  // F
    7'b0000110,  // E
    7'b0100001,  // d
    7'b1000110,  // C
    7'b0000011,  // b
    7'b0001000,  // A
    7'b0010000,  // 9
    7'b0000000,  // 8
    7'b1111000,  // 7
    7'b0000010,  // 6
    7'b0010010,  // 5
    7'b0011001,  // 4
    7'b0110000,  // 3
    7'b0100100,  // 2
    7'b1111001,  // 1
    7'b1000000   // 0
  };

endpackage

// File: rtl/btn_conditioner.sv
// Push-button conditioner: two-flop synchronizer, debounce counter and a
// registered rising-edge pulse. A button held through reset release produces
// no pulse until it has been seen released once.
module btn_conditioner #(
  parameter int DEB_CYCLES = 50000
) (
  input  logic clk,
  input  logic reset,
  input  logic btn,
  output logic pulse
);

  localparam int CW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CYCLES - 1);

  logic          sync1;
  logic          sync2;
  logic          level;
  logic          level_d;
  logic          armed;
  logic [CW-1:0] cnt;

  // Synchronizer; comes out of reset reading "pressed" so a held button never arms.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
    end else begin
      sync1 <= btn;
      sync2 <= sync1;
    end
  end

  // Accept a new level after DEB_CYCLES consecutive samples that differ from it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      level <= 1'b0;
      cnt   <= '0;
    end else if (sync2 == level) begin
      cnt <= '0;
    end else if (cnt == CNT_LAST) begin
      level <= sync2;
      cnt   <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  // One-cycle pulse on each accepted rising level, once the button has been seen low.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      level_d <= 1'b0;
      armed   <= 1'b0;
      pulse   <= 1'b0;
    end else begin
      level_d <= level;
      armed   <= armed | ~sync2;
      pulse   <= level & ~level_d & armed;
    end
  end

endmodule

// File: rtl/debug_display_ctrl.sv
// Debug front panel: run/step/halt control with a PC breakpoint, a probe
// address counter driven by buttons, and a multiplexed seven-segment display
// of a selectable probe source with per-frame snapshot and optional blanking.
module debug_display_ctrl
  import debug_pkg::*;
#(
  parameter int DIGIT      = 32,
  parameter int DEBUGSIZE  = 8,
  parameter int NUM_SRC    = 2,
  parameter int DEB_CYCLES = 50000,
  parameter int SCAN_DIV   = 100000,
  parameter int WRAP       = 1,
  parameter int BLANK      = 0
) (
  input  logic                                       CLK100MHZ,
  input  logic                                       reset,
  input  logic                                       cont,
  input  logic                                       step,
  input  logic                                       inc,
  input  logic                                       dec,
  input  logic [((NUM_SRC > 1) ? $clog2(NUM_SRC) : 1)-1:0] src_sel,
  input  logic                                       bp_en,
  input  logic [DEBUGSIZE-1:0]                       ProbePC,
  input  logic [NUM_SRC*DIGIT-1:0]                   ProbeData,
  output logic                                       run,
  output logic                                       halted,
  output logic [DEBUGSIZE-1:0]                       ProbeAddress,
  output logic [DEBUGSIZE-1:0]                       DisplayPC,
  output logic [DIGIT/4-1:0]                         AN,
  output logic [6:0]                                 seg
);

  localparam int NDIG = DIGIT / 4;
  localparam int DIGW = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam int PW   = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [PW-1:0]        PRESC_LAST = PW'(SCAN_DIV - 1);
  localparam logic [DIGW-1:0]      DIGIT_LAST = DIGW'(NDIG - 1);
  localparam logic [DEBUGSIZE-1:0] ADDR_MAX   = '1;

  logic cont_p;
  logic step_p;
  logic inc_p;
  logic dec_p;

  btn_conditioner #(.DEB_CYCLES(DEB_CYCLES)) u_cont (
    .clk(CLK100MHZ), .reset(reset), .btn(cont), .pulse(cont_p));
  btn_conditioner #(.DEB_CYCLES(DEB_CYCLES)) u_step (
    .clk(CLK100MHZ), .reset(reset), .btn(step), .pulse(step_p));
  btn_conditioner #(.DEB_CYCLES(DEB_CYCLES)) u_inc (
    .clk(CLK100MHZ), .reset(reset), .btn(inc), .pulse(inc_p));
  btn_conditioner #(.DEB_CYCLES(DEB_CYCLES)) u_dec (
    .clk(CLK100MHZ), .reset(reset), .btn(dec), .pulse(dec_p));

  // ---------------------------------------------------------------- run control
  run_state_t state;
  run_state_t state_nx;
  logic       run_entry;

  // State register; run_entry marks the first RUN cycle so a resume from the
  // breakpoint address does not halt on the spot.
  always_ff @(posedge CLK100MHZ or negedge reset) begin
    if (!reset) begin
      state     <= ST_HALT;
      run_entry <= 1'b0;
    end else begin
      state     <= state_nx;
      run_entry <= (state_nx == ST_RUN) && (state != ST_RUN);
    end
  end

  // Next state and run/halted decode; continue outranks step in HALT.
  always_comb begin
    state_nx = state;
    run      = 1'b0;
    halted   = 1'b0;
    case (state)
      ST_HALT: begin
        halted = 1'b1;
        if (cont_p) begin
          state_nx = ST_RUN;
        end else if (step_p) begin
          state_nx = ST_STEP;
        end
      end
      ST_STEP: begin
        run      = 1'b1;
        state_nx = ST_HALT;
      end
      ST_RUN: begin
        run = 1'b1;
        if (cont_p) begin
          state_nx = ST_HALT;
        end else if (bp_en && !run_entry && (ProbePC == ProbeAddress)) begin
          state_nx = ST_HALT;
        end
      end
      default: begin
        state_nx = ST_HALT;
      end
    endcase
  end

  // ------------------------------------------------------------ probe address
  // Address counter; simultaneous inc and dec cancel, ends wrap or saturate.
  always_ff @(posedge CLK100MHZ or negedge reset) begin
    if (!reset) begin
      ProbeAddress <= '0;
    end else if (inc_p && !dec_p) begin
      if (ProbeAddress != ADDR_MAX) begin
        ProbeAddress <= ProbeAddress + 1'b1;
      end else if (WRAP != 0) begin
        ProbeAddress <= '0;
      end
    end else if (dec_p && !inc_p) begin
      if (ProbeAddress != '0) begin
        ProbeAddress <= ProbeAddress - 1'b1;
      end else if (WRAP != 0) begin
        ProbeAddress <= ADDR_MAX;
      end
    end
  end

  // Registered copy of the CPU program counter.
  always_ff @(posedge CLK100MHZ or negedge reset) begin
    if (!reset) begin
      DisplayPC <= '0;
    end else begin
      DisplayPC <= ProbePC;
    end
  end

  // ------------------------------------------------------------------ display
  logic [PW-1:0]    presc;
  logic [DIGW-1:0]  digit;
  logic [DIGIT-1:0] frame;
  logic [DIGIT-1:0] sel_data;
  logic             scan_tick;

  assign scan_tick = (presc == PRESC_LAST);

  // Source mux; an out-of-range select falls back to source 0.
  always_comb begin
    sel_data = ProbeData[DIGIT-1:0];
    for (int k = 1; k < NUM_SRC; k++) begin
      if (int'(src_sel) == k) begin
        sel_data = ProbeData[k*DIGIT +: DIGIT];
      end
    end
  end

  // Prescaler and digit scan; the frame is re-latched as the scan returns to digit 0.
  always_ff @(posedge CLK100MHZ or negedge reset) begin
    if (!reset) begin
      presc <= '0;
      digit <= '0;
      frame <= '0;
    end else if (scan_tick) begin
      presc <= '0;
      if (digit == DIGIT_LAST) begin
        digit <= '0;
        frame <= sel_data;
      end else begin
        digit <= digit + 1'b1;
      end
    end else begin
      presc <= presc + 1'b1;
    end
  end

  logic [3:0]      nib;
  logic            blanked;
  logic [NDIG-1:0] an_nx;
  logic [6:0]      seg_nx;

  // Decode the current digit from the frame, applying leading-zero blanking.
  always_comb begin
    nib     = frame[int'(digit)*4 +: 4];
    blanked = 1'b0;
    if ((BLANK != 0) && (digit != '0)) begin
      blanked = ((frame >> (int'(digit) * 4)) == '0);
    end
    an_nx  = '1;
    seg_nx = SEG_BLANK;
    if (!blanked) begin
      an_nx[digit] = 1'b0;
      seg_nx       = SEG_TABLE[nib];
    end
  end

  // Registered display drive so reset holds every digit dark.
  always_ff @(posedge CLK100MHZ or negedge reset) begin
    if (!reset) begin
      AN  <= '1;
      seg <= SEG_BLANK;
    end else begin
      AN  <= an_nx;
      seg <= seg_nx;
    end
  end

endmodule

// File: tb/tb_debug_display_ctrl.sv
// Bench for debug_display_ctrl: two instances (wrapping + blanking, saturating
// + no blanking) share stimulus; a reference model queues expected output
// changes and a monitor compares each change the designs present.
module tb_debug_display_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        cont = 1'b0;
  logic        step = 1'b0;
  logic        inc = 1'b0;
  logic        dec = 1'b0;
  logic [1:0]  src_sel = 2'd1;
  logic        bp_en = 1'b0;
  logic [7:0]  ProbePC = 8'h00;
  logic [47:0] ProbeData = 48'h0;

  logic       run, halted, run_s, halted_s;
  logic [7:0] ProbeAddress, DisplayPC, ProbeAddress_s, DisplayPC_s;
  logic [3:0] AN, AN_s;
  logic [6:0] seg, seg_s;

  always #5 clk = ~clk;

  debug_display_ctrl #(.DIGIT(16), .DEBUGSIZE(8), .NUM_SRC(3), .DEB_CYCLES(4),
                       .SCAN_DIV(3), .WRAP(1), .BLANK(1)) dut (
    .CLK100MHZ(clk), .reset(reset), .cont(cont), .step(step), .inc(inc), .dec(dec),
    .src_sel(src_sel), .bp_en(bp_en), .ProbePC(ProbePC), .ProbeData(ProbeData),
    .run(run), .halted(halted), .ProbeAddress(ProbeAddress), .DisplayPC(DisplayPC),
    .AN(AN), .seg(seg));

  debug_display_ctrl #(.DIGIT(16), .DEBUGSIZE(8), .NUM_SRC(3), .DEB_CYCLES(4),
                       .SCAN_DIV(3), .WRAP(0), .BLANK(0)) dut_s (
    .CLK100MHZ(clk), .reset(reset), .cont(cont), .step(step), .inc(inc), .dec(dec),
    .src_sel(src_sel), .bp_en(bp_en), .ProbePC(ProbePC), .ProbeData(ProbeData),
    .run(run_s), .halted(halted_s), .ProbeAddress(ProbeAddress_s), .DisplayPC(DisplayPC_s),
    .AN(AN_s), .seg(seg_s));

  int n_checks = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  // ---------------------------------------------------------------- model
  logic [1:0]  st_q[$];       // {run, halted}
  logic [7:0]  addr_q[$];
  logic [7:0]  addr_s_q[$];
  logic [10:0] disp_q[$];     // {AN, seg}
  logic [10:0] disp_s_q[$];
  logic [10:0] last_d = 11'h7FF;
  logic [10:0] last_ds = 11'h7FF;
  bit          m_running = 0;
  logic [7:0]  m_addr = 8'h00;
  logic [7:0]  m_addr_s = 8'h00;

  function automatic logic [6:0] hex7(input logic [3:0] n);
    case (n)
      4'h0: return 7'h40;  4'h1: return 7'h79;  4'h2: return 7'h24;  4'h3: return 7'h30;
      4'h4: return 7'h19;  4'h5: return 7'h12;  4'h6: return 7'h02;  4'h7: return 7'h78;
      4'h8: return 7'h00;  4'h9: return 7'h10;  4'hA: return 7'h08;  4'hB: return 7'h03;
      4'hC: return 7'h46;  4'hD: return 7'h21;  4'hE: return 7'h06;  default: return 7'h0E;
    endcase
  endfunction

  function automatic logic [10:0] disp_val(input logic [15:0] f, input int dg, input bit blank);
    logic [3:0] sel;
    if (blank && dg > 0 && (f >> (4 * dg)) == 16'h0) return {4'hF, 7'h7F};
    sel = 4'hF & ~(4'b0001 << dg);
    return {sel, hex7(f[dg*4 +: 4])};
  endfunction

  // Queue the distinct display states one full frame of value f produces.
  task automatic push_frame(input logic [15:0] f);
    logic [10:0] v;
    for (int dg = 0; dg < 4; dg++) begin
      v = disp_val(f, dg, 1'b1);
      if (v != last_d) begin disp_q.push_back(v); last_d = v; end
      v = disp_val(f, dg, 1'b0);
      if (v != last_ds) begin disp_s_q.push_back(v); last_ds = v; end
    end
  endtask

  // Effect of one accepted press of the given button combination.
  task automatic model_pulse(input bit c, input bit s, input bit i, input bit d);
    logic [7:0] na;
    if (c) begin
      m_running = !m_running;
      st_q.push_back(m_running ? 2'b10 : 2'b01);
    end else if (s && !m_running) begin
      st_q.push_back(2'b10);
      st_q.push_back(2'b01);
    end
    if (i != d) begin
      na = i ? m_addr + 8'd1 : m_addr - 8'd1;
      if (na != m_addr) begin m_addr = na; addr_q.push_back(na); end
      if (i && m_addr_s != 8'hFF) begin m_addr_s = m_addr_s + 8'd1; addr_s_q.push_back(m_addr_s); end
      if (d && m_addr_s != 8'h00) begin m_addr_s = m_addr_s - 8'd1; addr_s_q.push_back(m_addr_s); end
    end
  endtask

  task automatic set_pc(input logic [7:0] v);
    ProbePC = v;
    if (m_running && bp_en && v == m_addr) begin
      m_running = 0;
      st_q.push_back(2'b01);
    end
  endtask

  // ---------------------------------------------------------------- monitor
  logic [1:0]  prev_st = 2'b01;
  logic [7:0]  prev_a = 8'h00;
  logic [7:0]  prev_as = 8'h00;
  logic [10:0] prev_d = 11'h7FF;
  logic [10:0] prev_ds = 11'h7FF;

  always @(negedge clk) begin
    if ({run, halted} != prev_st) begin
      if (st_q.size() > 0) check("run_halted", {30'd0, run, halted}, {30'd0, st_q.pop_front()});
      else check("run_halted_unexpected", {30'd0, run, halted}, {30'd0, prev_st});
      prev_st = {run, halted};
    end
    if (ProbeAddress != prev_a) begin
      if (addr_q.size() > 0) check("addr_wrap", {24'd0, ProbeAddress}, {24'd0, addr_q.pop_front()});
      else check("addr_wrap_unexpected", {24'd0, ProbeAddress}, {24'd0, prev_a});
      prev_a = ProbeAddress;
    end
    if (ProbeAddress_s != prev_as) begin
      if (addr_s_q.size() > 0) check("addr_sat", {24'd0, ProbeAddress_s}, {24'd0, addr_s_q.pop_front()});
      else check("addr_sat_unexpected", {24'd0, ProbeAddress_s}, {24'd0, prev_as});
      prev_as = ProbeAddress_s;
    end
    if ({AN, seg} != prev_d) begin
      if (disp_q.size() > 0) check("disp_blank", {21'd0, AN, seg}, {21'd0, disp_q.pop_front()});
      prev_d = {AN, seg};
    end
    if ({AN_s, seg_s} != prev_ds) begin
      if (disp_s_q.size() > 0) check("disp_noblank", {21'd0, AN_s, seg_s}, {21'd0, disp_s_q.pop_front()});
      prev_ds = {AN_s, seg_s};
    end
  end

  // ---------------------------------------------------------------- stimulus helpers
  task automatic press(input bit c, input bit s, input bit i, input bit d,
                       input int hold, input int gap, output int runs);
    model_pulse(c, s, i, d);
    runs = 0;
    cont = c; step = s; inc = i; dec = d;
    repeat (hold) begin @(negedge clk); if (run) runs++; end
    cont = 0; step = 0; inc = 0; dec = 0;
    repeat (gap) begin @(negedge clk); if (run) runs++; end
  endtask

  // Wait for the no-blank display to move onto digit 1.
  task automatic wait_d1();
    logic [3:0] p;
    bit found;
    found = 0;
    for (int i = 0; i < 60 && !found; i++) begin
      p = AN_s;
      @(negedge clk);
      if (AN_s == 4'b1101 && p != 4'b1101) found = 1;
    end
    n_checks++;
    if (!found) begin
      n_fail++;
      $display("FAIL wait_digit1: AN_s=%b, required 1101 within 60 cycles", AN_s);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_run"}, {31'd0, run}, 32'd0);
    check({tag, "_halted"}, {31'd0, halted}, 32'd1);
    check({tag, "_addr"}, {24'd0, ProbeAddress}, 32'd0);
    check({tag, "_dpc"}, {24'd0, DisplayPC}, 32'd0);
    check({tag, "_an"}, {28'd0, AN}, 32'hF);
    check({tag, "_seg"}, {25'd0, seg}, 32'h7F);
    check({tag, "_addr_s"}, {24'd0, ProbeAddress_s}, 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, required finish before 500000");
    $fatal(1, "watchdog");
  end

  initial begin
    int runs;
    int b;
    int waited;
    logic [7:0] r;

    ProbeData[31:16] = 16'h00A3;
    #1 reset = 0;
    #1 check_reset_outputs("reset");

    // Display: first frame is the reset frame, then the snapshot of source 1.
    push_frame(16'h0000);
    push_frame(16'h00A3);
    @(negedge clk);
    reset = 1;
    wait_d1();
    wait_d1();
    ProbeData[31:16] = 16'h1234;   // mid-frame change: current frame keeps 0x00A3
    push_frame(16'h1234);
    wait_d1();
    src_sel = 2'd3;                // out of range -> source 0
    ProbeData[15:0] = 16'h0007;
    push_frame(16'h0007);
    waited = 0;
    while ((disp_q.size() > 0 || disp_s_q.size() > 0) && waited < 100) begin
      @(negedge clk);
      waited++;
    end
    check("disp_queue_drained", disp_q.size() + disp_s_q.size(), 0);
    disp_q.delete();
    disp_s_q.delete();

    // Single step: exactly one run cycle.
    press(0, 1, 0, 0, 10, 12, runs);
    check("step_run_cycles", runs, 1);
    check("step_halted", {31'd0, halted}, 32'd1);

    // Continue and step together: continue wins, stays running.
    press(1, 1, 0, 0, 10, 12, runs);
    check("cont_step_run", {31'd0, run}, 32'd1);
    press(1, 0, 0, 0, 10, 12, runs);
    check("cont_again_halted", {31'd0, halted}, 32'd1);

    // Address counter ends: wrap vs saturate.
    press(0, 0, 0, 1, 8, 8, runs);
    check("dec_from_zero_wrap", {24'd0, ProbeAddress}, 32'hFF);
    check("dec_from_zero_sat", {24'd0, ProbeAddress_s}, 32'h00);
    for (int k = 0; k < 256; k++) press(0, 0, 1, 0, 8, 8, runs);
    check("inc_to_max_wrap", {24'd0, ProbeAddress}, 32'hFF);
    check("inc_at_max_sat", {24'd0, ProbeAddress_s}, 32'hFF);
    for (int k = 0; k < 6; k++) press(0, 0, 1, 0, 8, 8, runs);
    check("addr_at_bp", {24'd0, ProbeAddress}, 32'h05);

    // Random inc/dec mix, both pressed together sometimes.
    for (int k = 0; k < 12; k++) begin
      r = 8'($urandom_range(0, 2));
      press(0, 0, r != 8'd1, r != 8'd0, 8, 8, runs);
    end
    while (m_addr != 8'h05) press(0, 0, m_addr < 8'h05, m_addr > 8'h05, 8, 8, runs);

    // Breakpoint during RUN.
    press(1, 0, 0, 0, 10, 12, runs);
    bp_en = 1;
    set_pc(8'h03);
    @(negedge clk);
    check("dpc_03", {24'd0, DisplayPC}, 32'h03);
    check("bp_not_yet_03", {31'd0, halted}, 32'd0);
    set_pc(8'h04);
    @(negedge clk);
    check("dpc_04", {24'd0, DisplayPC}, 32'h04);
    check("bp_not_yet_04", {31'd0, halted}, 32'd0);
    set_pc(8'h05);
    @(negedge clk);
    check("bp_halted", {31'd0, halted}, 32'd1);
    check("dpc_05", {24'd0, DisplayPC}, 32'h05);

    // Resume from the breakpoint PC: the entry cycle must not re-halt.
    model_pulse(1, 0, 0, 0);
    cont = 1;
    b = 0;
    while (!run && b < 20) begin @(negedge clk); b++; end
    check("resume_run_seen", {31'd0, run}, 32'd1);
    @(negedge clk);
    check("resume_still_running", {31'd0, run}, 32'd1);
    set_pc(8'h06);
    repeat (8) @(negedge clk);
    cont = 0;
    repeat (12) @(negedge clk);
    check("resume_running_later", {31'd0, run}, 32'd1);
    press(1, 0, 0, 0, 10, 12, runs);
    bp_en = 0;

    // Bounce on inc: 2-cycle blips never reach the debounce threshold.
    for (int k = 0; k < 5; k++) begin
      inc = 1; repeat (2) @(negedge clk);
      inc = 0; repeat (2) @(negedge clk);
    end
    repeat (12) @(negedge clk);
    check("bounce_addr", {24'd0, ProbeAddress}, 32'h05);

    // Reset while running; step held across reset release must not fire.
    press(1, 0, 0, 0, 10, 12, runs);
    @(posedge clk);
    #2;
    m_running = 0;
    st_q.push_back(2'b01);
    if (m_addr != 8'h00) addr_q.push_back(8'h00);
    if (m_addr_s != 8'h00) addr_s_q.push_back(8'h00);
    m_addr = 8'h00;
    m_addr_s = 8'h00;
    reset = 0;
    #1;
    check("reset_run_same_cycle", {31'd0, run}, 32'd0);
    check_reset_outputs("reset_mid_run");
    step = 1;
    @(negedge clk);
    @(negedge clk);
    reset = 1;
    runs = 0;
    repeat (20) begin @(negedge clk); if (run) runs++; end
    step = 0;
    repeat (12) begin @(negedge clk); if (run) runs++; end
    check("held_step_no_pulse", runs, 0);
    press(0, 1, 0, 0, 10, 12, runs);
    check("step_after_release", runs, 1);

    waited = 0;
    while ((st_q.size() + addr_q.size() + addr_s_q.size()) > 0 && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    check("event_queues_drained", st_q.size() + addr_q.size() + addr_s_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/debug_display_ctrl.md
DEBUG_DISPLAY_CTRL -- requirements
Module: debug_display_ctrl

Interface
REQ-001 Parameter DIGIT, 32, display data width in bits; multiple of 4, 4..32; NDIG = DIGIT/4 digits.
REQ-002 Parameter DEBUGSIZE, 8, probe address / PC width.
REQ-003 Parameter NUM_SRC, 2, number of selectable probe data sources, 1..4.
REQ-004 Parameter DEB_CYCLES, 50000, stable cycles needed before a button level is accepted.
REQ-005 Parameter SCAN_DIV, 100000, clock cycles per displayed digit.
REQ-006 Parameter WRAP, 1, address counter mode: 1 = modulo 2^DEBUGSIZE, 0 = saturate.
REQ-007 Parameter BLANK, 0, 1 = leading-zero digit blanking enabled.
REQ-008 CLK100MHZ  in  1  single clock; all state on its rising edge.
REQ-009 reset  in  1  asynchronous, active-low reset.
REQ-010 cont, step, inc, dec  in  1 each  raw asynchronous push-buttons, active-high.
REQ-011 src_sel  in  clog2(NUM_SRC) (min 1)  display source select.
REQ-012 bp_en  in  1  breakpoint enable level.
REQ-013 ProbePC  in  DEBUGSIZE  current CPU PC.
REQ-014 ProbeData  in  NUM_SRC*DIGIT  packed sources; source k at [k*DIGIT +: DIGIT].
REQ-015 run  out  1  CPU clock enable.
REQ-016 halted  out  1  high in HALT state.
REQ-017 ProbeAddress  out  DEBUGSIZE  probe/breakpoint address.
REQ-018 DisplayPC  out  DEBUGSIZE  registered copy of ProbePC.
REQ-019 AN  out  NDIG  digit enables, active-low, one-hot-low.
REQ-020 seg  out  7  segments gfedcba, active-low.

Function
REQ-021 Each button passes a 2-flop synchronizer, then a debounce counter accepting a new level after DEB_CYCLES consecutive equal samples, then a rising-edge detector producing a one-cycle pulse (cont_p, step_p, inc_p, dec_p); total latency button->pulse = DEB_CYCLES+3 cycles.
REQ-022 Run FSM states HALT, STEP, RUN; run = 1 in STEP and RUN only; halted = 1 in HALT only.
REQ-023 HALT: cont_p -> RUN; else step_p -> STEP; cont_p wins when both pulse in the same cycle.
REQ-024 STEP: run high exactly one cycle, unconditionally -> HALT.
REQ-025 RUN: cont_p -> HALT; bp_en=1 and ProbePC==ProbeAddress -> HALT; step_p ignored.
REQ-026 Breakpoint is not re-checked on the RUN entry cycle, so resuming from a breakpoint PC does not halt immediately.
REQ-027 Address counter: inc_p alone +1, dec_p alone -1, both in the same cycle no change.
REQ-028 WRAP=1: max+1 -> 0, 0-1 -> max; WRAP=0: holds at max on inc, at 0 on dec.
REQ-029 Scan: prescaler counts 0..SCAN_DIV-1; on terminal count digit index advances 0..NDIG-1 then wraps to 0.
REQ-030 Frame snapshot: on digit index transition to 0, selected source (src_sel out-of-range -> source 0) latched into a DIGIT-bit frame register; display uses only the frame register.
REQ-031 AN[i] = 0 iff i == digit index and digit not blanked; seg = hex decode of frame nibble i (0 -> 1000000, F -> 0001110).
REQ-032 BLANK=1: digit i>0 blanked when all nibbles i..NDIG-1 of the frame are zero; blanked digit drives AN all ones, seg 1111111; digit 0 never blanked.
REQ-033 DisplayPC = ProbePC delayed one cycle.

Reset
REQ-034 reset low asynchronously forces: FSM HALT, run 0, halted 1, ProbeAddress 0, DisplayPC 0, frame 0, prescaler and digit index 0, AN all ones, seg 1111111, debouncers to accepted level 0 with counters cleared.
REQ-035 Reset mid-step or mid-run: run drops in the same cycle reset asserts; no pulse is generated from a button held through reset release until it is released and pressed again.

Structure
REQ-036 Shared package debug_pkg holds FSM state encoding, the 16-entry segment table, and the blank pattern constant.
REQ-037 One sub-module btn_conditioner (sync + debounce + edge detect, parameter DEB_CYCLES), instantiated four times; hex decode stays inline.

Verification (DEB_CYCLES=4, SCAN_DIV=3, DEBUGSIZE=8, DIGIT=16)
REQ-038 Reset, press step 10 cycles -> exactly one cycle with run=1, halted returns to 1.
REQ-039 In HALT press cont and step together -> RUN, run stays 1; press cont again -> HALT.
REQ-040 WRAP=1, address 0, press dec -> 0xFF; WRAP=0, address 0xFF, press inc -> stays 0xFF.
REQ-041 RUN, bp_en=1, ProbeAddress=0x05, ProbePC steps 0x03,0x04,0x05 -> halted=1 the cycle after PC=0x05.
REQ-042 ProbeData source1=0x00A3, src_sel=1, BLANK=1 -> AN cycles 1110,1101,1111,1111 with seg for 3 then A; change data mid-frame -> no change until next frame.
REQ-043 Button bounce of 2-cycle pulses on inc -> address unchanged; assert reset during RUN -> run=0 same cycle, all outputs at reset values.
